// File: rtl/regbank_dump_sequencer.sv
// Streams every register-bank word to the debug unit over valid/ready while the pipeline is halted.
// Latency: 2 cycles per word (READ + SEND); backpressure: o_data/o_index held in SEND until i_ready.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regbank_dump_sequencer #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_halted,
    input  logic                  i_abort,
    output logic                  o_rf_sel,
    output logic [ADDR_W-1:0]     o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_W-1:0]     o_index,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t                  state_q,   state_d;
    logic [ADDR_W-1:0]       idx_q,     idx_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic [ADDR_W-1:0]       index_q,   index_d;
    logic                    valid_q,   valid_d;
    logic                    rf_sel_q,  rf_sel_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;
    logic                    aborted_q, aborted_d;

    logic abort_req;

    // Losing the halt is treated exactly like an explicit abort: the write port may wake up.
    assign abort_req = i_abort || !i_halted;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        index_d   = index_q;
        valid_d   = valid_q;
        rf_sel_d  = rf_sel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                valid_d  = 1'b0;
                rf_sel_d = 1'b0;
                busy_d   = 1'b0;
                if (i_start && i_halted) begin
                    idx_d    = '0;
                    state_d  = S_READ;
                    rf_sel_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            S_READ: begin
                if (abort_req) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b0;
                    rf_sel_d  = 1'b0;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else begin
                    data_d  = i_rf_data;
                    index_d = idx_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                // Abort takes priority over a coinciding transfer; that word is not delivered.
                if (abort_req) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b0;
                    rf_sel_d  = 1'b0;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d  = S_DONE;
                        rf_sel_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                rf_sel_d = 1'b0;
                busy_d   = 1'b0;
            end

            default: begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                rf_sel_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            rf_sel_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            rf_sel_q  <= rf_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_rf_sel  = rf_sel_q;
    assign o_rf_addr = idx_q;
    assign o_data    = data_q;
    assign o_index   = index_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_aborted = aborted_q;

endmodule

// File: tb/tb_regbank_dump_sequencer.sv
// Directed bench for regbank_dump_sequencer: full dumps, backpressure, aborts and async reset.
module tb_regbank_dump_sequencer;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          halted = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic          rf_sel;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [DW-1:0] data_o;
    logic [AW-1:0] idx_o;
    logic          valid;
    logic          busy;
    logic          done;
    logic          aborted;

    logic [DW-1:0] bank [N];

    int checks = 0;
    int errors = 0;

    regbank_dump_sequencer #(.NUM_REGS(N), .DATA_WIDTH(DW)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_halted  (halted),
        .i_abort   (abort),
        .o_rf_sel  (rf_sel),
        .o_rf_addr (rf_addr),
        .i_rf_data (rf_data),
        .o_data    (data_o),
        .o_index   (idx_o),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_busy    (busy),
        .o_done    (done),
        .o_aborted (aborted)
    );

    assign rf_data = bank[rf_addr];

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one dump from the first READ cycle until o_busy falls; mode 0 = ready high, mode 1 = 3-low/1-high.
    task automatic drain(input int mode, input int budget,
                         output int nx, output int order_err, output int stab_err,
                         output int ndone, output int busy_cyc, output int last_c,
                         output int done_c, output bit timeout);
        logic [DW-1:0] pd;
        logic [AW-1:0] pi;
        bit            hold;
        nx = 0; order_err = 0; stab_err = 0; ndone = 0; busy_cyc = 0;
        last_c = -10; done_c = -20; timeout = 1'b1; hold = 1'b0;
        pd = '0; pi = '0;
        for (int c = 0; c < budget; c++) begin
            ready = (mode == 0) ? 1'b1 : ((c % 4) == 3);
            if (hold && valid && (data_o !== pd || idx_o !== pi)) stab_err++;
            if (busy) busy_cyc++;
            if (done) begin ndone++; done_c = c; end
            if (valid && ready) begin
                if (idx_o !== AW'(nx) || data_o !== (32'h100 + 32'(nx))) order_err++;
                nx++;
                last_c = c;
                hold = 1'b0;
            end else begin
                hold = valid;
                pd = data_o;
                pi = idx_o;
            end
            if (!busy) begin timeout = 1'b0; break; end
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if ({valid, busy, rf_sel, done, aborted} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {valid, busy, rf_sel, done, aborted}); end
        checks++; if ({data_o, idx_o, rf_addr} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", data_o, idx_o, rf_addr); end
        tick(); tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if ({valid, busy, rf_sel, done, aborted} !== 5'b0) begin errors++; $display("FAIL reset_release: got %b expected 00000", {valid, busy, rf_sel, done, aborted}); end
    endtask

    task automatic test_basic;
        int nx, oe, se, nd, bc, lc, dc;
        bit to;
        halted = 1'b1;
        pulse_start();
        checks++; if ({busy, rf_sel, valid} !== 3'b110) begin errors++; $display("FAIL basic_read_cycle: got %b expected 110", {busy, rf_sel, valid}); end
        drain(0, 200, nx, oe, se, nd, bc, lc, dc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: busy still %b after budget", busy); end
        checks++; if (nx != 32) begin errors++; $display("FAIL basic_count: got %0d expected 32", nx); end
        checks++; if (oe != 0) begin errors++; $display("FAIL basic_order: got %0d bad words expected 0", oe); end
        checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
        checks++; if (dc != lc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", dc, lc + 1); end
        checks++; if (bc != 65) begin errors++; $display("FAIL basic_span: got %0d cycles expected 65", bc); end
    endtask

    task automatic test_backpressure;
        int nx, oe, se, nd, bc, lc, dc;
        bit to;
        halted = 1'b1;
        pulse_start();
        drain(1, 600, nx, oe, se, nd, bc, lc, dc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: busy still %b after budget", busy); end
        checks++; if (nx != 32) begin errors++; $display("FAIL bp_count: got %0d expected 32", nx); end
        checks++; if (oe != 0) begin errors++; $display("FAIL bp_order: got %0d bad words expected 0", oe); end
        checks++; if (se != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", se); end
        checks++; if (nd != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", nd); end
    endtask

    task automatic test_start_not_halted;
        int bad;
        bad = 0;
        halted = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ({busy, rf_sel, valid} !== 3'b000) bad++;
        end
        start = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL not_halted: got %0d active cycles expected 0", bad); end
        checks++; if ({done, aborted} !== 2'b00) begin errors++; $display("FAIL not_halted_pulse: got %b expected 00", {done, aborted}); end
    endtask

    task automatic test_halt_drop;
        int nx, oe, se, nd, bc, lc, dc, extra;
        bit to, found;
        halted = 1'b1;
        ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid && idx_o == 5'd7) begin found = 1'b1; break; end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL drop_reach7: got idx %0d expected 7 in SEND", idx_o); end
        halted = 1'b0;
        tick();
        checks++; if ({aborted, rf_sel, busy, valid, done} !== 5'b10000) begin errors++; $display("FAIL drop_abort: got %b expected 10000", {aborted, rf_sel, busy, valid, done}); end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (aborted || done || busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL drop_quiet: got %0d active cycles expected 0", extra); end
        halted = 1'b1;
        pulse_start();
        drain(0, 200, nx, oe, se, nd, bc, lc, dc, to);
        checks++; if (nx != 32 || oe != 0) begin errors++; $display("FAIL drop_restart: got %0d words %0d bad expected 32 0", nx, oe); end
        checks++; if (nd != 1) begin errors++; $display("FAIL drop_restart_done: got %0d expected 1", nd); end
    endtask

    task automatic test_abort_collision;
        int delivered, extra;
        bit found;
        halted = 1'b1;
        ready = 1'b1;
        pulse_start();
        delivered = 0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid && idx_o == 5'd5) begin found = 1'b1; break; end
            if (valid && ready) delivered++;
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL coll_reach5: got idx %0d expected 5 in SEND", idx_o); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready = 1'b0;
        checks++; if ({aborted, busy, valid, done} !== 4'b1000) begin errors++; $display("FAIL coll_abort: got %b expected 1000", {aborted, busy, valid, done}); end
        checks++; if (delivered != 5) begin errors++; $display("FAIL coll_delivered: got %0d expected 5", delivered); end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done || busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL coll_no_done: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_async_reset;
        int nx, oe, se, nd, bc, lc, dc;
        bit to;
        halted = 1'b1;
        ready = 1'b0;
        pulse_start();
        tick();
        checks++; if ({valid, busy, rf_sel} !== 3'b111) begin errors++; $display("FAIL areset_pre: got %b expected 111", {valid, busy, rf_sel}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({valid, busy, rf_sel, done, aborted} !== 5'b0 || {data_o, idx_o, rf_addr} !== '0) begin
            errors++; $display("FAIL areset_clear: got ctrl %b data %h idx %h addr %h expected 0", {valid, busy, rf_sel, done, aborted}, data_o, idx_o, rf_addr);
        end
        #2 rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle: got busy %b expected 0", busy); end
        pulse_start();
        drain(0, 200, nx, oe, se, nd, bc, lc, dc, to);
        checks++; if (nx != 32 || oe != 0 || nd != 1) begin errors++; $display("FAIL areset_restart: got %0d words %0d bad %0d done expected 32 0 1", nx, oe, nd); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) bank[k] = 32'h100 + 32'(k);
        test_reset();
        test_basic();
        test_backpressure();
        test_start_not_halted();
        test_halt_drop();
        test_abort_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
